neuron_mac_lanes: RTL and testbench

- Multi-lane successor to the serial dot-product neuron: y = act(sum(mask[i] ? x[i]*w[i] : 0) + bias), quantized and saturated to OUT_W.
- Processes LANES elements per cycle.
- Skips all-zero mask groups at zero cycle cost.
- Adds a registered product pipeline, an op tag passthrough and a saturation flag.
- Sits between the layer sequencer (valid/ready in) and the activation buffer (valid/ready out with backpressure).

---
 rtl/neuron_mac_lanes.sv | 238 +++++++++++++++++++++++
 tb/tb_neuron_mac_lanes.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_lanes.sv
// Multi-lane masked dot-product neuron: bias + sum of masked x*w, LANES products per cycle,
// all-zero mask groups skipped, then activation, rescale and saturation to OUT_W.
module neuron_mac_lanes #(
    parameter int NUM_INPUTS = 16,
    parameter int LANES      = 4,
    parameter int X_W        = 8,
    parameter int W_W        = 8,
    parameter int B_W        = 32,
    parameter int OUT_W      = 16,
    parameter int X_FRAC     = 4,
    parameter int W_FRAC     = 4,
    parameter int B_FRAC     = 8,
    parameter int OUT_FRAC   = 8,
    parameter int GUARD_BITS = 2,
    parameter int LEAK_SHIFT = 2,
    parameter int TAG_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [B_W-1:0]          bias,
    input  logic [NUM_INPUTS*X_W-1:0] x_flat,
    input  logic [NUM_INPUTS*W_W-1:0] w_flat,
    input  logic [NUM_INPUTS-1:0]   mask_flat,
    input  logic [1:0]              act_sel,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_sat,
    output logic                    busy,
    output logic [2:0]              state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid and its payload are held unchanged until that edge, in_ready is high only in IDLE.

    localparam int NUM_GROUPS = NUM_INPUTS / LANES;
    localparam int PROD_W     = X_W + W_W;
    localparam int FRAC_P     = X_FRAC + W_FRAC;
    localparam int ACC_W      = PROD_W + $clog2(NUM_INPUTS) + GUARD_BITS;
    localparam int UP_SH      = (OUT_FRAC > FRAC_P) ? OUT_FRAC - FRAC_P : 0;
    localparam int DN_SH      = (FRAC_P > OUT_FRAC) ? FRAC_P - OUT_FRAC : 0;
    localparam int BS_UP      = (FRAC_P > B_FRAC) ? FRAC_P - B_FRAC : 0;
    localparam int BS_DN      = (B_FRAC > FRAC_P) ? B_FRAC - FRAC_P : 0;
    localparam int EXT_BASE   = ACC_W + UP_SH;
    localparam int EXT_W      = ((EXT_BASE > OUT_W) ? EXT_BASE : OUT_W) + 1;

    localparam logic signed [ACC_W-1:0] ONE_P  = ACC_W'(1) << FRAC_P;
    localparam logic signed [EXT_W-1:0] SAT_HI = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_LO = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_QUANT = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [NUM_INPUTS*X_W-1:0] x_q;
    logic [NUM_INPUTS*W_W-1:0] w_q;
    logic [NUM_INPUTS-1:0]     mask_q;
    logic [1:0]                act_q;
    logic [TAG_W-1:0]          tag_q;
    logic [NUM_GROUPS-1:0]     pend;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   psum;
    logic                      psum_v;

    logic [NUM_GROUPS-1:0]     gnz_in;
    logic [NUM_GROUPS-1:0]     sel_onehot;
    logic [NUM_GROUPS-1:0]     pend_left;
    logic                      sel_found;
    logic signed [ACC_W-1:0]   psum_nx;
    logic signed [X_W-1:0]     xs;
    logic signed [W_W-1:0]     ws;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   act_v;
    logic signed [EXT_W-1:0]   scaled;
    logic [OUT_W-1:0]          q_data;
    logic                      q_sat;

    // Right shift with rounding half away from zero (magnitude rounded, sign restored).
    function automatic logic signed [EXT_W-1:0] rshift_round(input logic signed [EXT_W-1:0] v,
                                                             input int sh);
        logic signed [EXT_W-1:0] mag;
        logic signed [EXT_W-1:0] half;
        if (sh == 0) return v;
        half = EXT_W'(1) <<< (sh - 1);
        mag  = (v < 0) ? -v : v;
        mag  = (mag + half) >>> sh;
        return (v < 0) ? -mag : mag;
    endfunction

    function automatic logic signed [ACC_W-1:0] align_bias(input logic signed [B_W-1:0] b);
        logic signed [ACC_W-1:0] t;
        logic signed [EXT_W-1:0] e;
        t = ACC_W'(b);
        if (B_FRAC <= FRAC_P) return t <<< BS_UP;
        e = EXT_W'(t);
        e = rshift_round(e, BS_DN);
        return e[ACC_W-1:0];
    endfunction

    always_comb begin
        gnz_in = '0;
        for (int g = 0; g < NUM_GROUPS; g++) gnz_in[g] = |mask_flat[g*LANES +: LANES];
    end

    // Lowest pending nonzero group and its masked partial sum.
    always_comb begin
        sel_found  = 1'b0;
        sel_onehot = '0;
        psum_nx    = '0;
        xs         = '0;
        ws         = '0;
        prod       = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (!sel_found && pend[g]) begin
                sel_found     = 1'b1;
                sel_onehot[g] = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    if (mask_q[g*LANES + l]) begin
                        xs      = x_q[(g*LANES + l)*X_W +: X_W];
                        ws      = w_q[(g*LANES + l)*W_W +: W_W];
                        prod    = xs * ws;
                        psum_nx = psum_nx + ACC_W'(prod);
                    end
                end
            end
        end
        pend_left = pend & ~sel_onehot;
    end

    always_comb begin
        act_v = acc;
        case (act_q)
            2'b01:   act_v = (acc < 0) ? '0 : acc;
            2'b10:   act_v = (acc < 0) ? (acc >>> LEAK_SHIFT) : acc;
            2'b11: begin
                if (acc > ONE_P) act_v = ONE_P;
                else if (acc < -ONE_P) act_v = -ONE_P;
            end
            default: act_v = acc;
        endcase
        if (UP_SH > 0) scaled = EXT_W'(act_v) <<< UP_SH;
        else scaled = rshift_round(EXT_W'(act_v), DN_SH);
        q_sat  = 1'b0;
        q_data = scaled[OUT_W-1:0];
        if (scaled > SAT_HI) begin
            q_data = SAT_HI[OUT_W-1:0];
            q_sat  = 1'b1;
        end else if (scaled < SAT_LO) begin
            q_data = SAT_LO[OUT_W-1:0];
            q_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid) state_nx = (|gnz_in) ? S_ISSUE : S_DRAIN;
            S_ISSUE: if (pend_left == '0) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_QUANT;
            S_QUANT: state_nx = S_OUT;
            S_OUT:   if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            w_q       <= '0;
            mask_q    <= '0;
            act_q     <= '0;
            tag_q     <= '0;
            pend      <= '0;
            acc       <= '0;
            psum      <= '0;
            psum_v    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q    <= x_flat;
                        w_q    <= w_flat;
                        mask_q <= mask_flat;
                        act_q  <= act_sel;
                        tag_q  <= in_tag;
                        pend   <= gnz_in;
                        acc    <= align_bias($signed(bias));
                        psum_v <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    psum   <= psum_nx;
                    psum_v <= 1'b1;
                    pend   <= pend_left;
                    if (psum_v) acc <= acc + psum;
                end
                S_DRAIN: begin
                    if (psum_v) acc <= acc + psum;
                    psum_v <= 1'b0;
                end
                S_QUANT: begin
                    out_data  <= q_data;
                    out_sat   <= q_sat;
                    out_tag   <= tag_q;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Bench for neuron_mac_lanes: directed plan cases plus random ops checked against an
// arithmetic reference model; back-to-back ops go through an expected-result queue.
module tb_neuron_mac_lanes;

    localparam int NI = 16;
    localparam int XW = 8;
    localparam int OW = 16;
    localparam int TW = 4;
    localparam int EW = TW + 1 + OW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     bias = '0;
    logic [NI*XW-1:0] x_flat = '0;
    logic [NI*XW-1:0] w_flat = '0;
    logic [NI-1:0]   mask_flat = '0;
    logic [1:0]      act_sel = '0;
    logic [TW-1:0]   in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OW-1:0]   out_data;
    logic [TW-1:0]   out_tag;
    logic            out_sat;
    logic            busy;
    logic [2:0]      state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [EW-1:0] exp_q[$];

    neuron_mac_lanes dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bias(bias),
        .x_flat(x_flat), .w_flat(w_flat), .mask_flat(mask_flat), .act_sel(act_sel),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_sat(out_sat), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NI*XW-1:0] fill(input logic [7:0] v);
        logic [NI*XW-1:0] r;
        for (int i = 0; i < NI; i++) r[i*XW +: XW] = v;
        return r;
    endfunction

    function automatic logic [NI*XW-1:0] rand_vec();
        logic [NI*XW-1:0] r;
        for (int i = 0; i < NI; i++) r[i*XW +: XW] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    function automatic logic [NI-1:0] rand_mask();
        logic [NI-1:0] m;
        for (int g = 0; g < NI/4; g++) begin
            case ($urandom_range(0, 2))
                0:       m[g*4 +: 4] = 4'h0;
                1:       m[g*4 +: 4] = 4'hF;
                default: m[g*4 +: 4] = 4'($urandom_range(0, 15));
            endcase
        end
        return m;
    endfunction

    // Reference: real-valued dot product in the product (Q.8) domain, activation, saturate.
    function automatic void model(input logic [NI*XW-1:0] xf, input logic [NI*XW-1:0] wf,
                                  input logic [NI-1:0] m, input logic [31:0] b,
                                  input logic [1:0] a, output logic [OW-1:0] d,
                                  output logic s, output int k);
        longint v;
        v = longint'($signed(b));
        k = 0;
        for (int i = 0; i < NI; i++)
            if (m[i]) v += longint'($signed(xf[i*XW +: XW])) * longint'($signed(wf[i*XW +: XW]));
        for (int g = 0; g < NI/4; g++) if (m[g*4 +: 4] != 4'h0) k++;
        case (a)
            2'b01: if (v < 0) v = 0;
            2'b10: if (v < 0) v = v >>> 2;
            2'b11: begin
                if (v > 256) v = 256;
                if (v < -256) v = -256;
            end
            default: ;
        endcase
        s = 1'b0;
        if (v > 32767) begin v = 32767; s = 1'b1; end
        if (v < -32768) begin v = -32768; s = 1'b1; end
        d = v[OW-1:0];
    endfunction

    // Driver: issue one op, return the result and edges from accept to out_valid (-1 on timeout).
    task automatic run_op(input logic [NI*XW-1:0] xf, input logic [NI*XW-1:0] wf,
                          input logic [NI-1:0] m, input logic [31:0] b, input logic [1:0] a,
                          input logic [TW-1:0] t, input bit hold, output logic [OW-1:0] d,
                          output logic [TW-1:0] tg, output logic s, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        x_flat = xf; w_flat = wf; mask_flat = m; bias = b; act_sel = a; in_tag = t;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
        d = out_data; tg = out_tag; s = out_sat;
        if (!hold && lat > 0) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, out_data, out_tag, out_sat, busy} !== {1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0})
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h tag=%h sat=%b busy=%b expected rdy=1 vld=0 data=0 tag=0 sat=0 busy=0",
                     in_ready, out_valid, out_data, out_tag, out_sat, busy);
        else n_pass++;
    endtask

    task automatic test_dense();
        logic [OW-1:0] d; logic [TW-1:0] tg; logic s; int lat;
        run_op(fill(8'd16), fill(8'd16), 16'hFFFF, 32'd0, 2'b00, 4'd5, 1'b0, d, tg, s, lat);
        n_checks++;
        if (d !== 16'd4096) $display("FAIL dense_data: got %0d expected 4096", $signed(d)); else n_pass++;
        n_checks++;
        if (tg !== 4'd5) $display("FAIL dense_tag: got %0d expected 5", tg); else n_pass++;
        n_checks++;
        if (s !== 1'b0) $display("FAIL dense_sat: got %b expected 0", s); else n_pass++;
        n_checks++;
        if (lat !== 6) $display("FAIL dense_latency: got %0d expected 6", lat); else n_pass++;
    endtask

    task automatic test_sparse_act();
        logic [OW-1:0] d; logic [TW-1:0] tg; logic s; int lat;
        logic [1:0] acts[3] = '{2'b01, 2'b10, 2'b00};
        int exps[3] = '{0, -448, -1792};
        for (int i = 0; i < 3; i++) begin
            run_op(fill(8'd32), fill(8'hF0), 16'h00F0, 32'd256, acts[i], 4'(i + 1), 1'b0, d, tg, s, lat);
            n_checks++;
            if ($signed(d) !== 16'(exps[i]))
                $display("FAIL sparse_act%0d_data: got %0d expected %0d", acts[i], $signed(d), exps[i]);
            else n_pass++;
            n_checks++;
            if (lat !== 3) $display("FAIL sparse_act%0d_latency: got %0d expected 3", acts[i], lat); else n_pass++;
        end
    endtask

    task automatic test_bias_only();
        logic [OW-1:0] d; logic [TW-1:0] tg; logic s; int lat;
        run_op(rand_vec(), rand_vec(), 16'h0000, 32'h1234, 2'b00, 4'd7, 1'b0, d, tg, s, lat);
        n_checks++;
        if ({d, s} !== {16'h1234, 1'b0}) $display("FAIL bias_only: got data=%h sat=%b expected data=1234 sat=0", d, s); else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL bias_only_latency: got %0d expected 2", lat); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [OW-1:0] d; logic [TW-1:0] tg; logic s; int lat;
        run_op(fill(8'd127), fill(8'd127), 16'hFFFF, 32'd0, 2'b00, 4'd1, 1'b0, d, tg, s, lat);
        n_checks++;
        if ({d, s} !== {16'h7FFF, 1'b1}) $display("FAIL sat_pos: got data=%h sat=%b expected data=7fff sat=1", d, s); else n_pass++;
        run_op(fill(8'd127), fill(8'd127), 16'hFFFF, 32'd0, 2'b11, 4'd2, 1'b0, d, tg, s, lat);
        n_checks++;
        if ({d, s} !== {16'd256, 1'b0}) $display("FAIL sat_clamp: got data=%h sat=%b expected data=0100 sat=0", d, s); else n_pass++;
        run_op(fill(8'h80), fill(8'd127), 16'hFFFF, 32'd0, 2'b00, 4'd3, 1'b0, d, tg, s, lat);
        n_checks++;
        if ({d, s} !== {16'h8000, 1'b1}) $display("FAIL sat_neg: got data=%h sat=%b expected data=8000 sat=1", d, s); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] d; logic [TW-1:0] tg; logic s; int lat;
        run_op(fill(8'd32), fill(8'hF0), 16'h00F0, 32'd256, 2'b00, 4'd9, 1'b1, d, tg, s, lat);
        n_checks++;
        if ({d, tg, s} !== {16'hF900, 4'd9, 1'b0}) $display("FAIL bp_result: got data=%h tag=%0d sat=%b expected data=f900 tag=9 sat=0", d, tg, s); else n_pass++;
        x_flat = fill(8'd1); w_flat = fill(8'd1); mask_flat = 16'hFFFF; in_tag = 4'd12; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, out_data, out_tag, out_sat} !== {1'b1, 1'b0, 16'hF900, 4'd9, 1'b0})
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b data=%h tag=%0d sat=%b expected vld=1 rdy=0 data=f900 tag=9 sat=0",
                         i, out_valid, in_ready, out_data, out_tag, out_sat);
            else n_pass++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, busy} !== {1'b0, 1'b1, 1'b0})
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b expected vld=0 rdy=1 busy=0", out_valid, in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [NI*XW-1:0] xf, wf; logic [NI-1:0] m; logic [31:0] b; logic [1:0] a; logic [TW-1:0] t;
        logic [OW-1:0] d, ed; logic [TW-1:0] tg; logic s, es; int lat, k;
        for (int n = 0; n < 24; n++) begin
            xf = rand_vec(); wf = rand_vec(); m = rand_mask();
            b = 32'($signed($urandom_range(0, 131072)) - 65536);
            a = 2'($urandom_range(0, 3)); t = 4'($urandom_range(0, 15));
            model(xf, wf, m, b, a, ed, es, k);
            run_op(xf, wf, m, b, a, t, 1'b0, d, tg, s, lat);
            n_checks++;
            if ({d, tg, s} !== {ed, t, es})
                $display("FAIL rand%0d_result: got data=%h tag=%0d sat=%b expected data=%h tag=%0d sat=%b", n, d, tg, s, ed, t, es);
            else n_pass++;
            n_checks++;
            if (lat !== k + 2) $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, k + 2); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        int got;
        out_ready = 1'b1;
        fork
            begin
                logic [NI*XW-1:0] xf, wf; logic [NI-1:0] m; logic [31:0] b; logic [1:0] a;
                logic [OW-1:0] ed; logic es; int k, prev_k, prev_cyc, w;
                prev_k = 0; prev_cyc = 0;
                for (int n = 0; n < N; n++) begin
                    xf = rand_vec(); wf = rand_vec(); m = rand_mask();
                    b = 32'($signed($urandom_range(0, 4096)) - 2048);
                    a = 2'($urandom_range(0, 3));
                    model(xf, wf, m, b, a, ed, es, k);
                    w = 0;
                    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
                    x_flat = xf; w_flat = wf; mask_flat = m; bias = b; act_sel = a; in_tag = 4'(n + 3);
                    exp_q.push_back({4'(n + 3), es, ed});
                    in_valid = 1'b1;
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    if (n > 0) begin
                        n_checks++;
                        if (cyc - prev_cyc !== prev_k + 4)
                            $display("FAIL b2b%0d_interval: got %0d expected %0d", n, cyc - prev_cyc, prev_k + 4);
                        else n_pass++;
                    end
                    prev_cyc = cyc; prev_k = k;
                end
            end
            begin
                logic [EW-1:0] e;
                got = 0;
                for (int c = 0; c < 3000 && got < N; c++) begin
                    @(posedge clk); #1;
                    if (out_valid) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL b2b_spurious: got data=%h tag=%0d expected no output", out_data, out_tag);
                        end else begin
                            e = exp_q.pop_front();
                            if ({out_tag, out_sat, out_data} !== e)
                                $display("FAIL b2b%0d_result: got tag=%0d sat=%b data=%h expected tag=%0d sat=%b data=%h",
                                         got, out_tag, out_sat, out_data, e[EW-1 -: TW], e[OW], e[OW-1:0]);
                            else n_pass++;
                        end
                        got++;
                    end
                end
            end
        join
        out_ready = 1'b0;
        n_checks++;
        if (got !== N) $display("FAIL b2b_count: got %0d results expected %0d", got, N); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] d; logic [TW-1:0] tg; logic s; int lat, seen;
        x_flat = rand_vec(); w_flat = rand_vec(); mask_flat = 16'hFFFF; bias = 32'd1000;
        act_sel = 2'b00; in_tag = 4'd14; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, out_data, out_tag, out_sat, busy} !== {1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0})
            $display("FAIL midreset_state: got rdy=%b vld=%b data=%h tag=%h sat=%b busy=%b expected rdy=1 vld=0 data=0 tag=0 sat=0 busy=0",
                     in_ready, out_valid, out_data, out_tag, out_sat, busy);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen); else n_pass++;
        run_op(fill(8'd16), fill(8'd16), 16'hFFFF, 32'd0, 2'b00, 4'd6, 1'b0, d, tg, s, lat);
        n_checks++;
        if ({d, tg, s} !== {16'd4096, 4'd6, 1'b0})
            $display("FAIL midreset_next: got data=%0d tag=%0d sat=%b expected data=4096 tag=6 sat=0", d, tg, s);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dense();
        test_sparse_act();
        test_bias_only();
        test_saturation();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
